mac_dot_seq: RTL and testbench

//   Operand sequencer and accumulator controller for one mac1 cell. Accepts a stream of
//   8-bit activation/weight pairs over valid/ready and drives them into the MAC.

---
 rtl/mac_dot_seq.sv | 129 ++++++++++++
 tb/tb_mac_dot_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_seq.sv
// Operand sequencer / accumulator controller feeding one mac1 cell; returns one dot product per vector.
// Optional MAC_DOT_SEQ_OVF_EN adds a sticky per-vector wrap flag on out_ovf.
module mac_dot_seq #(
    parameter int LEN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_w,
    output logic [7:0]       mac_a,
    output logic [7:0]       mac_w,
    output logic [23:0]      mac_carry_in,
    input  logic [23:0]      mac_temp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [23:0]      out_sum,
`ifdef MAC_DOT_SEQ_OVF_EN
    output logic             out_ovf,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ACC, CAPT, DONE} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len_q;
    logic             take;

    assign take = in_valid & in_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (take) state_nxt = (cfg_len == '0) ? CAPT : ACC;
            ACC:  if (take && count == len_q) state_nxt = CAPT;
            CAPT: state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Term 0 always forces carry_in=0 so a stale MAC sum never leaks into a new vector.
    always_comb begin
        in_ready     = 1'b0;
        mac_a        = 8'd0;
        mac_w        = 8'd0;
        mac_carry_in = 24'd0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mac_a = in_a;
                    mac_w = in_w;
                end
            end
            ACC: begin
                in_ready     = 1'b1;
                mac_carry_in = mac_temp;
                if (in_valid) begin
                    mac_a = in_a;
                    mac_w = in_w;
                end
            end
            CAPT: mac_carry_in = mac_temp;
`ifdef MAC_DOT_SEQ_OVF_EN
            DONE: mac_carry_in = mac_temp;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            len_q     <= '0;
            out_sum   <= 24'd0;
            out_valid <= 1'b0;
        end else begin
            if (take && state == IDLE) begin
                len_q <= cfg_len;
                count <= {{(LEN_W-1){1'b0}}, 1'b1};
            end else if (take && state == ACC) begin
                count <= count + 1'b1;
            end
            if (state == CAPT) begin
                out_sum   <= mac_temp;
                out_valid <= 1'b1;
            end else if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MAC_DOT_SEQ_OVF_EN
    // A sum smaller than the carry it was built on means the 24-bit accumulator wrapped.
    logic [23:0] prev_carry;
    logic        chk_q;
    logic        ovf_sticky;
    logic        wrap;

    assign wrap = chk_q && (mac_temp < prev_carry);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_carry <= 24'd0;
            chk_q      <= 1'b0;
            ovf_sticky <= 1'b0;
            out_ovf    <= 1'b0;
        end else begin
            chk_q <= take;
            if (take) prev_carry <= mac_carry_in;
            if (take && state == IDLE) ovf_sticky <= 1'b0;
            else                       ovf_sticky <= ovf_sticky | wrap;
            if (state == CAPT) out_ovf <= ovf_sticky | wrap;
        end
    end
`endif

endmodule

// File: tb/tb_mac_dot_seq.sv
// Self-checking bench for mac_dot_seq: a behavioural mac1 model closes the carry loop,
// table vectors and random vectors are compared against plain-arithmetic dot products.
module tb_mac_dot_seq;

`ifdef MAC_DOT_SEQ_OVF_EN
    localparam int LEN_W = 9;
`else
    localparam int LEN_W = 8;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_a = 8'd0;
    logic [7:0]       in_w = 8'd0;
    logic [7:0]       mac_a, mac_w;
    logic [23:0]      mac_carry_in;
    logic [23:0]      mac_temp = 24'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [23:0]      out_sum;
    logic             busy;
`ifdef MAC_DOT_SEQ_OVF_EN
    logic             out_ovf;
`endif

    int checks = 0;
    int errors = 0;

    mac_dot_seq #(.LEN_W(LEN_W)) dut (
        .clock(clock), .reset(reset), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_w(in_w),
        .mac_a(mac_a), .mac_w(mac_w), .mac_carry_in(mac_carry_in), .mac_temp(mac_temp),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
`ifdef MAC_DOT_SEQ_OVF_EN
        .out_ovf(out_ovf),
`endif
        .busy(busy)
    );

    always #5 clock = ~clock;

    // mac1 behaviour: temp = a*w + carry_in, registered on the issue edge, no reset.
    logic [15:0] mac_prod;
    assign mac_prod = mac_a * mac_w;
    always @(posedge clock) mac_temp <= mac_carry_in + {8'd0, mac_prod};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drives one vector from negedges; gaps[i] bubbles precede term i; hold = cycles of out_ready=0.
    task automatic run_vec(input string name, input logic [7:0] qa[$], input logic [7:0] qw[$],
                           input int gaps[$], input int hold, input logic [23:0] exp_sum,
                           input logic exp_ovf);
        logic [23:0] part;
        int n;
        n = qa.size();
        part = 24'd0;
        out_ready = (hold == 0);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                in_valid = 1'b0;
                in_a = 8'($urandom);
                in_w = 8'($urandom);
                #1;
                chk({name, " bubble in_ready"}, 32'(in_ready), 32'd1);
                chk({name, " bubble mac_a"}, 32'(mac_a), 32'd0);
                chk({name, " bubble carry"}, 32'(mac_carry_in), 32'(part));
                @(negedge clock);
            end
            in_valid = 1'b1;
            in_a = qa[i];
            in_w = qw[i];
            cfg_len = (i == 0) ? LEN_W'(n - 1) : LEN_W'($urandom);
            #1;
            chk({name, " in_ready"}, 32'(in_ready), 32'd1);
            chk({name, " mac_a"}, 32'(mac_a), 32'(qa[i]));
            chk({name, " carry"}, 32'(mac_carry_in), 32'(part));
            part = part + 24'(qa[i]) * 24'(qw[i]);
            @(negedge clock);
        end
        in_valid = 1'b0;
        #1;
        chk({name, " capt out_valid"}, 32'(out_valid), 32'd0);
        chk({name, " capt in_ready"}, 32'(in_ready), 32'd0);
        @(negedge clock);
        chk({name, " out_valid"}, 32'(out_valid), 32'd1);
        chk({name, " out_sum"}, 32'(out_sum), 32'(exp_sum));
`ifdef MAC_DOT_SEQ_OVF_EN
        chk({name, " out_ovf"}, 32'(out_ovf), 32'(exp_ovf));
`else
        if (exp_ovf) chk({name, " no-wrap expected"}, 32'(exp_ovf), 32'd0);
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk({name, " hold out_valid"}, 32'(out_valid), 32'd1);
            chk({name, " hold out_sum"}, 32'(out_sum), 32'(exp_sum));
            chk({name, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        chk({name, " release out_valid"}, 32'(out_valid), 32'd0);
        chk({name, " release busy"}, 32'(busy), 32'd0);
        out_ready = 1'b0;
    endtask

    typedef struct packed {
        int               n;
        logic [7:0][7:0]  a;
        logic [7:0][7:0]  w;
        logic [7:0][7:0]  gap;
        int               hold;
        logic [23:0]      exp_sum;
    } vec_t;

    // Reference: full-precision dot product, reported modulo 2^24 with a wrap indication.
    function automatic logic [24:0] ref_dot(input logic [7:0] qa[$], input logic [7:0] qw[$]);
        longint s;
        s = 0;
        foreach (qa[i]) s += longint'(qa[i]) * longint'(qw[i]);
        return {(s >= 64'd16777216), s[23:0]};
    endfunction

    initial begin
        vec_t        tbl[6];
        logic [7:0]  qa[$], qw[$];
        int          qg[$];
        logic [24:0] r;

        tbl[0] = '{n:4, a:{32'd0, 8'd7, 8'd5, 8'd3, 8'd1}, w:{32'd0, 8'd8, 8'd6, 8'd4, 8'd2},
                   gap:64'd0, hold:0, exp_sum:24'd100};
        tbl[1] = '{n:1, a:{56'd0, 8'd255}, w:{56'd0, 8'd255}, gap:64'd0, hold:0, exp_sum:24'd65025};
        tbl[2] = '{n:3, a:{40'd0, 8'd1, 8'd4, 8'd2}, w:{40'd0, 8'd1, 8'd5, 8'd3},
                   gap:{40'd0, 8'd0, 8'd2, 8'd0}, hold:0, exp_sum:24'd27};
        tbl[3] = '{n:3, a:{40'd0, 8'd0, 8'd1, 8'd9}, w:{40'd0, 8'd5, 8'd2, 8'd9},
                   gap:64'd0, hold:5, exp_sum:24'd83};
        tbl[4] = '{n:1, a:{56'd0, 8'd1}, w:{56'd0, 8'd1}, gap:64'd0, hold:0, exp_sum:24'd1};
        tbl[5] = '{n:8, a:{8{8'd255}}, w:{8{8'd255}}, gap:{8'd0, 8'd1, 8'd0, 8'd3, 8'd0, 8'd0, 8'd1, 8'd2},
                   hold:2, exp_sum:24'd520200};

        #12;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_sum", 32'(out_sum), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset carry", 32'(mac_carry_in), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int t = 0; t < 6; t++) begin
            qa = {}; qw = {}; qg = {};
            for (int i = 0; i < tbl[t].n; i++) begin
                qa.push_back(tbl[t].a[i]);
                qw.push_back(tbl[t].w[i]);
                qg.push_back(int'(tbl[t].gap[i]));
            end
            run_vec($sformatf("tbl%0d", t), qa, qw, qg, tbl[t].hold, tbl[t].exp_sum, 1'b0);
        end

        // Reset mid-vector: partial sum discarded, outputs cleared at once.
        in_valid = 1'b1; cfg_len = LEN_W'(3); in_a = 8'd7; in_w = 8'd7;
        @(negedge clock);
        in_a = 8'd3; in_w = 8'd3;
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_sum", 32'(out_sum), 32'd0);
        chk("midrst mac_a", 32'(mac_a), 32'd0);
        chk("midrst carry", 32'(mac_carry_in), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        qa = {8'd10, 8'd10}; qw = {8'd10, 8'd10}; qg = {0, 0};
        run_vec("post_rst", qa, qw, qg, 0, 24'd200, 1'b0);

        for (int v = 0; v < 30; v++) begin
            int n;
            n = $urandom_range(1, 20);
            qa = {}; qw = {}; qg = {};
            for (int i = 0; i < n; i++) begin
                qa.push_back(8'($urandom));
                qw.push_back(8'($urandom));
                qg.push_back(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
            end
            r = ref_dot(qa, qw);
            run_vec($sformatf("rnd%0d", v), qa, qw, qg, $urandom_range(0, 3), r[23:0], r[24]);
        end

`ifdef MAC_DOT_SEQ_OVF_EN
        qa = {}; qw = {}; qg = {};
        for (int i = 0; i < 300; i++) begin
            qa.push_back(8'd255); qw.push_back(8'd255); qg.push_back(0);
        end
        r = ref_dot(qa, qw);
        chk("ovf ref wraps", 32'(r[24]), 32'd1);
        run_vec("ovf300", qa, qw, qg, 0, r[23:0], r[24]);
        qa = {8'd1}; qw = {8'd1}; qg = {0};
        run_vec("ovf_clear", qa, qw, qg, 0, 24'd1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
